// File: rtl/sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sdf_stage_ctrl
// Purpose  : Sequencing controller for one radix-2 single-path delay-feedback
//            (SDF) FFT stage. Tracks the sample position in the input stream
//            and drives the butterfly/twiddle mode select, the delay-line
//            shift enable, the output valid and the twiddle ROM address. After
//            the last sample it drains the feedback delay line, pulses done,
//            and keeps a sticky framing-error flag.
// Ports    : clk       - stage clock, rising edge
//            rst       - asynchronous reset, active high
//            in_valid  - input sample present this cycle
//            in_last   - final sample of the stream (only with in_valid)
//            in_ready  - controller accepts input (low only while draining)
//            mode      - 0 load delay line, 1 butterfly, 2 twiddle output
//            dl_shift  - delay line advances this cycle
//            out_valid - stage output sample valid this cycle
//            tw_addr   - twiddle ROM address (ROM is combinational)
//            busy      - controller is not idle
//            done      - one-cycle pulse after the drain completes
//            err       - sticky framing-error flag
// Revision : 1.0 - initial release
// ============================================================================
module sdf_stage_ctrl #(
    parameter int HALF      = 512,
    parameter int CW        = 9,
    parameter int TW_STRIDE = 1,
    parameter int TW_AW     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [1:0]       mode,
    output logic             dl_shift,
    output logic             out_valid,
    output logic [TW_AW-1:0] tw_addr,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_BFLY  = 3'd2;
    localparam logic [2:0] S_TWID  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [CW-1:0] C_CNT_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_accept;
    logic             w_cnt_last;
    logic             w_tw_en;
    logic [TW_AW-1:0] w_tw_prod;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // in_ready is low only in DRAIN, so acceptance reduces to this.
    assign w_accept   = in_valid & (r_state != S_DRAIN);
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                // The accepted sample here is FILL position 0.
                if (w_accept) begin
                    w_state_nxt = S_FILL;
                    w_cnt_nxt   = C_CNT_ONE;
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_BFLY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end
            end
            S_BFLY: begin
                if (w_accept) begin
                    if (w_cnt_last) begin
                        w_state_nxt = in_last ? S_DRAIN : S_TWID;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end
            end
            S_TWID: begin
                if (w_accept) begin
                    if (w_cnt_last) begin
                        w_state_nxt = S_BFLY;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + C_CNT_ONE;
                    end
                end
            end
            S_DRAIN: begin
                // Drain is free-running: the delay line empties regardless of input.
                if (w_cnt_last) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + C_CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // in_last is only legal on the final BFLY sample of a frame pair.
        if (w_accept && in_last && !((r_state == S_BFLY) && w_cnt_last)) begin
            w_err_nxt = 1'b1;
        end
        // Samples offered while draining are dropped and flagged.
        if ((r_state == S_DRAIN) && in_valid) begin
            w_err_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (zero latency relative to the sample on the bus)
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b1;
        mode      = 2'd0;
        dl_shift  = 1'b0;
        out_valid = 1'b0;
        w_tw_en   = 1'b0;
        case (r_state)
            S_IDLE, S_FILL: begin
                dl_shift = in_valid;
            end
            S_BFLY: begin
                mode      = 2'd1;
                dl_shift  = in_valid;
                out_valid = in_valid;
            end
            S_TWID: begin
                mode      = 2'd2;
                dl_shift  = in_valid;
                out_valid = in_valid;
                w_tw_en   = 1'b1;
            end
            S_DRAIN: begin
                in_ready  = 1'b0;
                mode      = 2'd2;
                dl_shift  = 1'b1;
                out_valid = 1'b1;
                w_tw_en   = 1'b1;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // Product computed directly at ROM-address width: truncation is intended,
    // letting a small stage index into a larger shared ROM.
    assign w_tw_prod = TW_AW'(r_cnt) * TW_AW'(TW_STRIDE);
    assign tw_addr   = w_tw_en ? w_tw_prod : '0;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdf_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdf_stage_ctrl
// Purpose  : Directed, table-driven bench for sdf_stage_ctrl. A HALF=4 instance
//            runs the stream/gap/error vectors; a HALF=8, stride-2 instance
//            checks strided twiddle addressing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdf_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_last;
    logic       in_ready, dl_shift, out_valid, busy, done, err;
    logic [1:0] mode;
    logic [9:0] tw_addr;

    logic       v8, l8;
    logic       rdy8, sh8, ov8, busy8, done8, err8;
    logic [1:0] mode8;
    logic [3:0] tw8;

    sdf_stage_ctrl #(.HALF(4), .CW(2), .TW_STRIDE(1), .TW_AW(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mode(mode), .dl_shift(dl_shift),
        .out_valid(out_valid), .tw_addr(tw_addr), .busy(busy),
        .done(done), .err(err)
    );

    sdf_stage_ctrl #(.HALF(8), .CW(3), .TW_STRIDE(2), .TW_AW(4)) dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_last(l8),
        .in_ready(rdy8), .mode(mode8), .dl_shift(sh8),
        .out_valid(ov8), .tw_addr(tw8), .busy(busy8),
        .done(done8), .err(err8)
    );

    typedef struct {
        string      name;
        logic       v;
        logic       l;
        logic       rdy;
        logic [1:0] mode;
        logic       sh;
        logic       ov;
        logic [9:0] tw;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic void add(string nm, bit v, bit l, bit rdy, logic [1:0] m,
                                bit sh, bit ov, int tw, bit bsy, bit dn, bit er);
        vec_t t;
        t.name = nm; t.v = v; t.l = l; t.rdy = rdy; t.mode = m; t.sh = sh;
        t.ov = ov; t.tw = 10'(tw); t.busy = bsy; t.done = dn; t.err = er;
        q.push_back(t);
    endfunction

    // Expected-output builders, one per controller phase.
    function automatic void idle(string nm, bit v, bit l, bit dn, bit er);
        add(nm, v, l, 1, 2'd0, v, 0, 0, 0, dn, er);
    endfunction
    function automatic void fill(string nm, bit v, bit l, bit er);
        add(nm, v, l, 1, 2'd0, v, 0, 0, 1, 0, er);
    endfunction
    function automatic void bfly(string nm, bit v, bit l, bit er);
        add(nm, v, l, 1, 2'd1, v, v, 0, 1, 0, er);
    endfunction
    function automatic void twid(string nm, bit v, bit l, int tw, bit er);
        add(nm, v, l, 1, 2'd2, v, v, tw, 1, 0, er);
    endfunction
    function automatic void drain(string nm, bit v, int tw, bit er);
        add(nm, v, 0, 0, 2'd2, 1, 1, tw, 1, 0, er);
    endfunction

    // Drive each vector at the falling edge, compare 1 ns later.
    task automatic run_table();
        foreach (q[i]) begin
            @(negedge clk);
            in_valid = q[i].v;
            in_last  = q[i].l;
            #1;
            chk($sformatf("%s[%0d]", q[i].name, i),
                {14'd0, in_ready, mode, dl_shift, out_valid, tw_addr, busy, done, err},
                {14'd0, q[i].rdy, q[i].mode, q[i].sh, q[i].ov, q[i].tw, q[i].busy,
                 q[i].done, q[i].err});
        end
        q.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 0; in_last = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        chk("reset_clears", {28'd0, busy, done, err, in_ready}, 32'h1);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_last = 0; v8 = 0; l8 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        // 8-sample stream, then a 16-sample stream started in the done cycle.
        idle("t1_reset", 0, 0, 0, 0);
        idle("t1_s1", 1, 0, 0, 0);
        repeat (3) fill("t1_fill", 1, 0, 0);
        repeat (3) bfly("t1_bfly", 1, 0, 0);
        bfly("t1_bfly_last", 1, 1, 0);
        for (int k = 0; k < 4; k++) drain("t1_drain", 0, k, 0);
        idle("t2_s1_in_done", 1, 0, 1, 0);
        repeat (3) fill("t2_fill", 1, 0, 0);
        repeat (4) bfly("t2_bfly_a", 1, 0, 0);
        for (int k = 0; k < 4; k++) twid("t2_twid", 1, 0, k, 0);
        repeat (3) bfly("t2_bfly_b", 1, 0, 0);
        bfly("t2_bfly_last", 1, 1, 0);
        for (int k = 0; k < 4; k++) drain("t2_drain", 0, k, 0);
        idle("t2_done", 0, 0, 1, 0);
        idle("t2_idle", 0, 0, 0, 0);
        run_table();

        // Gaps of 3 cycles after samples 2, 6 and 10; in_last without in_valid is harmless.
        idle("t3_s1", 1, 0, 0, 0);
        fill("t3_s2", 1, 0, 0);
        fill("t3_gapf", 0, 0, 0); fill("t3_gapf", 0, 1, 0); fill("t3_gapf", 0, 0, 0);
        fill("t3_s3", 1, 0, 0); fill("t3_s4", 1, 0, 0);
        bfly("t3_s5", 1, 0, 0); bfly("t3_s6", 1, 0, 0);
        repeat (3) bfly("t3_gapb", 0, 0, 0);
        bfly("t3_s7", 1, 0, 0); bfly("t3_s8", 1, 0, 0);
        twid("t3_s9", 1, 0, 0, 0); twid("t3_s10", 1, 0, 1, 0);
        repeat (3) twid("t3_gapt", 0, 0, 2, 0);
        twid("t3_s11", 1, 0, 2, 0); twid("t3_s12", 1, 0, 3, 0);
        repeat (3) bfly("t3_bfly", 1, 0, 0);
        bfly("t3_s16", 1, 1, 0);
        for (int k = 0; k < 4; k++) drain("t3_drain", 0, k, 0);
        idle("t3_done", 0, 0, 1, 0);
        run_table();

        // Early in_last in FILL: err sticks, sequencing unchanged.
        idle("t4_s1", 1, 0, 0, 0);
        fill("t4_s2", 1, 0, 0);
        fill("t4_s3_last", 1, 1, 0);
        fill("t4_s4", 1, 0, 1);
        repeat (3) bfly("t4_bfly", 1, 0, 1);
        bfly("t4_bfly_last", 1, 1, 1);
        for (int k = 0; k < 4; k++) drain("t4_drain", 0, k, 1);
        idle("t4_done", 0, 0, 1, 1);
        idle("t4_idle", 0, 0, 0, 1);
        run_table();
        pulse_reset();

        // in_valid held through DRAIN: err set, drain still exactly 4 cycles.
        idle("t5_s1", 1, 0, 0, 0);
        repeat (3) fill("t5_fill", 1, 0, 0);
        repeat (3) bfly("t5_bfly", 1, 0, 0);
        bfly("t5_bfly_last", 1, 1, 0);
        drain("t5_drain", 1, 0, 0);
        for (int k = 1; k < 4; k++) drain("t5_drain", 1, k, 1);
        idle("t5_done", 0, 0, 1, 1);
        idle("t5_idle", 0, 0, 0, 1);
        run_table();
        pulse_reset();

        // in_last inside BFLY before its final position: err, then on to TWID.
        idle("t6_s1", 1, 0, 0, 0);
        repeat (3) fill("t6_fill", 1, 0, 0);
        bfly("t6_s5", 1, 0, 0);
        bfly("t6_s6_last", 1, 1, 0);
        bfly("t6_s7", 1, 0, 1);
        bfly("t6_s8", 1, 0, 1);
        twid("t6_twid", 0, 0, 0, 1);
        run_table();
        pulse_reset();

        // Reset mid-BFLY: outputs return to reset values at once, no done follows.
        idle("t7_s1", 1, 0, 0, 0);
        repeat (3) fill("t7_fill", 1, 0, 0);
        bfly("t7_s5", 1, 0, 0);
        run_table();
        @(negedge clk);
        in_valid = 1; in_last = 0;
        #1;
        chk("t7_pre_rst_mode", {30'd0, mode}, 32'd1);
        #1;
        in_valid = 0;
        rst = 1;
        #1;
        chk("t7_rst_outputs",
            {14'd0, in_ready, mode, dl_shift, out_valid, tw_addr, busy, done, err},
            {14'd0, 1'b1, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t7_no_done[%0d]", k), {29'd0, busy, done, in_ready}, 32'h1);
        end

        // HALF=8, stride 2: twiddle addresses 0,2,..,14 in TWID and in DRAIN.
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            v8 = 1; l8 = (k == 31);
            #1;
            chk($sformatf("t8_s%0d", k + 1), {26'd0, mode8, tw8},
                {26'd0, (k < 8) ? 2'd0 : (k < 16) ? 2'd1 : (k < 24) ? 2'd2 : 2'd1,
                 (k >= 16 && k < 24) ? 4'(2 * (k - 16)) : 4'd0});
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v8 = 0; l8 = 0;
            #1;
            chk($sformatf("t8_drain%0d", k), {25'd0, rdy8, mode8, tw8},
                {25'd0, 1'b0, 2'd2, 4'(2 * k)});
        end
        @(negedge clk);
        #1;
        chk("t8_done", {28'd0, busy8, done8, err8, rdy8}, 32'h5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdf_stage_ctrl.md
Name: sdf_stage_ctrl

Overview:
- Sequencing controller for one radix-2 single-path delay-feedback (SDF) FFT stage.
- Tracks sample position in the input stream and drives the stage's butterfly/twiddle mode select, delay-line shift enable and output valid.
- Generates the address into the shared twiddle ROM.
- Handles the post-stream drain of the feedback delay line and reports framing errors.

Parameters:
- HALF, 512, delay-line length (N/2 for the stage); power of two, >= 2.
- CW, 9, counter width = log2(HALF).
- TW_STRIDE, 1, twiddle address step per sample (lets smaller stages share a larger ROM).
- TW_AW, 10, twiddle address width.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input sample present this cycle.
- in_last  in  1  qualifies the final sample of the stream; meaningful only with in_valid.
- in_ready  out  1  controller accepts input; low only in DRAIN.
- mode  out  2  0 = load delay line, 1 = butterfly, 2 = twiddle output; 3 is never driven.
- dl_shift  out  1  delay line advances this cycle.
- out_valid  out  1  stage output sample valid this cycle.
- tw_addr  out  TW_AW  twiddle ROM address (ROM is combinational).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the drain completes.
- err  out  1  sticky framing-error flag.

Behaviour:
- Registers: state (IDLE, FILL, BFLY, TWID, DRAIN), cnt[CW-1:0], err, done.
- Reset: async on rst=1, with state=IDLE, cnt=0, err=0, done=0.
- Reset output values: in_ready=1, mode=0, dl_shift=0, out_valid=0, tw_addr=0, busy=0.
- Reset asserted mid-frame aborts immediately. No drain and no done pulse follow.
- Accepted step: in_valid & in_ready. In FILL/BFLY/TWID the counter advances only on accepted steps, so gaps stall the stage. DRAIN advances every cycle.
- Outputs are combinational decode of state/cnt, gated by in_valid where noted. Zero added latency relative to the sample on the bus.
- IDLE: mode=0, dl_shift=in_valid. An accepted step is FILL position 0: go to FILL with cnt=1.
- FILL: mode=0, dl_shift=in_valid, out_valid=0. An accepted step at cnt=HALF-1 goes to BFLY with cnt=0; otherwise cnt+1.
- BFLY: mode=1, dl_shift=out_valid=in_valid.
  - Accepted step at cnt=HALF-1 with in_last=1: go to DRAIN, cnt=0.
  - Same with in_last=0: go to TWID, cnt=0.
  - Otherwise cnt+1.
- TWID: mode=2, dl_shift=out_valid=in_valid, tw_addr=cnt*TW_STRIDE truncated to TW_AW. An accepted step at cnt=HALF-1 goes to BFLY with cnt=0.
- DRAIN: in_ready=0, mode=2, dl_shift=1, out_valid=1, tw_addr=cnt*TW_STRIDE. At cnt=HALF-1 go to IDLE and set done=1 for the next cycle only.
- tw_addr=0 in every state other than TWID/DRAIN.
- Latency: the first out_valid coincides with accepted sample number HALF+1. The final output is HALF cycles after the last accepted sample.
- Framing errors set err=1 (sticky, cleared only by rst). Control flow is unaffected.
  - Accepted step with in_last=1 in IDLE, FILL or TWID.
  - Accepted step with in_last=1 in BFLY at cnt != HALF-1.
  - in_valid=1 during DRAIN; the sample is ignored.
- Wrap: cnt returns to 0 at every phase boundary and never exceeds HALF-1.
- Streams are multiples of 2*HALF samples. Back-to-back streams need IDLE to be re-entered; a sample offered in the done cycle is accepted as FILL position 0.

Test Plan:
- HALF=4, STRIDE=1, 8 contiguous samples, in_last on sample 8.
  - mode 0,0,0,0 then 1,1,1,1.
  - out_valid first high on sample 5.
  - Then 4 DRAIN cycles with tw_addr 0,1,2,3, in_ready=0, mode=2.
  - done pulses one cycle later; busy=0 after that.
- HALF=4, 16 contiguous samples, in_last on sample 16 -> mode sequence 0×4, 1×4, 2×4 (tw_addr 0..3), 1×4, then DRAIN×4, then done.
- HALF=4, gap inserted after samples 2 and 6 (in_valid=0 for 3 cycles each) -> during gaps cnt, state, tw_addr hold and dl_shift=out_valid=0. Phase boundaries are still counted in accepted samples only.
- HALF=4, in_last on sample 3 -> err=1 and remains 1. Sequencing continues to BFLY after sample 4.
- HALF=4, in_valid held high through DRAIN -> err=1, DRAIN length still exactly 4 cycles.
- HALF=8, TW_STRIDE=2, TW_AW=4, 16 samples then 8 TWID samples -> tw_addr 0,2,4,…,14.
- Separately, rst asserted during BFLY -> all outputs at reset values the same cycle, and no done pulse follows.
